// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - autonomous register-write sequencer with host-priority bus arbitration
//
// Purpose: plays up to 8 programmed {delay, address, data} steps onto the
//          signal_generator write bus, spaced by tick-based delays. Direct
//          host writes share the same bus and always take priority.
// Ports:
//    i_clk, i_rst          clock, asynchronous active-high reset
//    i_prog_we/addr/data   program-memory write port {delay, address, data}
//    i_start, i_stop       playback control pulses (stop dominates)
//    i_loop, i_length      wrap enable and active entry count (clamped to 8)
//    i_host_*              direct host write request
//    o_write_strobe/address/data   registered write bus to signal_generator
//    o_busy, o_step_idx, o_done    playback status
module sound_sequencer #(
   parameter int TICK_DIV = 1000,
   parameter int DELAY_W  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_prog_we,
   input  logic [2:0]           i_prog_addr,
   input  logic [8+DELAY_W-1:0] i_prog_data,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_loop,
   input  logic [3:0]           i_length,
   input  logic                 i_host_strobe,
   input  logic [2:0]           i_host_address,
   input  logic [4:0]           i_host_data,
   output logic                 o_write_strobe,
   output logic [2:0]           o_address,
   output logic [4:0]           o_data,
   output logic                 o_busy,
   output logic [2:0]           o_step_idx,
   output logic                 o_done
);

   localparam int ENT_W = 8 + DELAY_W;
   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

   state_t               r_state, w_state_nxt;
   logic [2:0]           r_step_idx, w_step_nxt;
   logic [PW-1:0]        r_presc, w_presc_nxt;
   logic [DELAY_W-1:0]   r_dly, w_dly_nxt;
   logic [ENT_W-1:0]     r_mem [8];
   logic [DELAY_W-1:0]   r_ent_dly;
   logic [2:0]           r_ent_addr;
   logic [4:0]           r_ent_data;
   logic                 r_ws;
   logic [2:0]           r_addr;
   logic [4:0]           r_data;
   logic                 r_done;

   logic [ENT_W-1:0]     w_fetch;
   logic [3:0]           w_len;
   logic                 w_last;
   logic                 w_latch;
   logic                 w_seq_issue;
   logic                 w_advance;
   logic                 w_done_nxt;

   assign w_fetch = r_mem[r_step_idx];
   assign w_len   = (i_length > 4'd8) ? 4'd8 : i_length;
   // ">=" rather than "==" so a length shrunk below the current step still ends playback
   assign w_last  = (({1'b0, r_step_idx} + 4'd1) >= w_len);

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step_idx;
      w_presc_nxt = r_presc;
      w_dly_nxt   = r_dly;
      w_latch     = 1'b0;
      w_seq_issue = 1'b0;
      w_advance   = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: ;
         S_FETCH: begin
            w_latch     = 1'b1;
            w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            // a host write owns the bus this cycle; retry next cycle
            if (!i_host_strobe) begin
               w_seq_issue = 1'b1;
               w_dly_nxt   = r_ent_dly;
               w_presc_nxt = '0;
               if (r_ent_dly == '0) w_advance = 1'b1;
               else                 w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_presc == PRESC_MAX) begin
               w_presc_nxt = '0;
               w_dly_nxt   = r_dly - 1'b1;
               if (r_dly <= 1) w_advance = 1'b1;
            end else begin
               w_presc_nxt = r_presc + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_advance) begin
         if (w_last) begin
            w_step_nxt = 3'd0;
            if (i_loop) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end else begin
            w_step_nxt  = r_step_idx + 3'd1;
            w_state_nxt = S_FETCH;
         end
      end

      if (i_start && (w_len != 4'd0)) begin
         w_state_nxt = S_FETCH;
         w_step_nxt  = 3'd0;
         w_presc_nxt = '0;
         w_dly_nxt   = '0;
         w_seq_issue = 1'b0;
         w_done_nxt  = 1'b0;
      end

      if (i_stop) begin
         w_state_nxt = S_IDLE;
         w_step_nxt  = 3'd0;
         w_presc_nxt = '0;
         w_dly_nxt   = '0;
         w_seq_issue = 1'b0;
         w_done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_step_idx <= 3'd0;
         r_presc    <= '0;
         r_dly      <= '0;
         r_ent_dly  <= '0;
         r_ent_addr <= 3'd0;
         r_ent_data <= 5'd0;
         r_ws       <= 1'b0;
         r_addr     <= 3'd0;
         r_data     <= 5'd0;
         r_done     <= 1'b0;
         for (int i = 0; i < 8; i++) r_mem[i] <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_step_idx <= w_step_nxt;
         r_presc    <= w_presc_nxt;
         r_dly      <= w_dly_nxt;
         r_done     <= w_done_nxt;
         if (i_prog_we) r_mem[i_prog_addr] <= i_prog_data;
         if (w_latch) begin
            r_ent_dly  <= w_fetch[ENT_W-1:8];
            r_ent_addr <= w_fetch[7:5];
            r_ent_data <= w_fetch[4:0];
         end
         if (i_host_strobe) begin
            r_ws   <= 1'b1;
            r_addr <= i_host_address;
            r_data <= i_host_data;
         end else if (w_seq_issue) begin
            r_ws   <= 1'b1;
            r_addr <= r_ent_addr;
            r_data <= r_ent_data;
         end else begin
            r_ws   <= 1'b0;
         end
      end
   end

   assign o_write_strobe = r_ws;
   assign o_address      = r_addr;
   assign o_data         = r_data;
   assign o_busy         = (r_state != S_IDLE);
   assign o_step_idx     = r_step_idx;
   assign o_done         = r_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - directed table-driven bench for sound_sequencer
module tb_sound_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prog_we = 1'b0;
   logic [2:0]  prog_addr = '0;
   logic [11:0] prog_data = '0;
   logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [3:0]  length = '0;
   logic        host_strobe = 1'b0;
   logic [2:0]  host_address = '0;
   logic [4:0]  host_data = '0;
   logic        write_strobe, busy, done;
   logic [2:0]  address, step_idx;
   logic [4:0]  data;

   int n_cmp = 0;
   int n_err = 0;

   sound_sequencer #(.TICK_DIV(4), .DELAY_W(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_data(prog_data),
      .i_start(start), .i_stop(stop), .i_loop(loop), .i_length(length),
      .i_host_strobe(host_strobe), .i_host_address(host_address), .i_host_data(host_data),
      .o_write_strobe(write_strobe), .o_address(address), .o_data(data),
      .o_busy(busy), .o_step_idx(step_idx), .o_done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [3:0] len;
      logic       ws;
      logic [2:0] a;
      logic [4:0] d;
      logic       busy;
      logic [2:0] step;
      logic       done;
   } vec_t;

   vec_t tbl [10];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc_chk(input string tag, input int c, input bit ews, input logic [2:0] ea,
                          input logic [4:0] ed, input bit eb, input bit edn);
      @(posedge clk); #1;
      cmp($sformatf("%s c%0d strobe", tag, c), write_strobe, ews);
      if (ews) begin
         cmp($sformatf("%s c%0d address", tag, c), address, ea);
         cmp($sformatf("%s c%0d data", tag, c), data, ed);
      end
      cmp($sformatf("%s c%0d busy", tag, c), busy, eb);
      cmp($sformatf("%s c%0d done", tag, c), done, edn);
   endtask

   task automatic prog(input logic [2:0] idx, input logic [3:0] dly, input logic [2:0] a, input logic [4:0] d);
      prog_we = 1'b1; prog_addr = idx; prog_data = {dly, a, d};
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'd2, 1'b0, 3'd0, 5'd0, 1'b1, 3'd0, 1'b0};
      tbl[1] = '{1'b0, 4'd2, 1'b0, 3'd0, 5'd0, 1'b1, 3'd0, 1'b0};
      tbl[2] = '{1'b0, 4'd2, 1'b1, 3'd0, 5'd5, 1'b1, 3'd0, 1'b0};
      tbl[3] = '{1'b0, 4'd2, 1'b0, 3'd0, 5'd5, 1'b1, 3'd0, 1'b0};
      tbl[4] = '{1'b0, 4'd2, 1'b0, 3'd0, 5'd5, 1'b1, 3'd0, 1'b0};
      tbl[5] = '{1'b0, 4'd2, 1'b0, 3'd0, 5'd5, 1'b1, 3'd0, 1'b0};
      tbl[6] = '{1'b0, 4'd2, 1'b0, 3'd0, 5'd5, 1'b1, 3'd1, 1'b0};
      tbl[7] = '{1'b0, 4'd2, 1'b0, 3'd0, 5'd5, 1'b1, 3'd1, 1'b0};
      tbl[8] = '{1'b0, 4'd2, 1'b1, 3'd2, 5'd9, 1'b0, 3'd0, 1'b1};
      tbl[9] = '{1'b0, 4'd2, 1'b0, 3'd2, 5'd9, 1'b0, 3'd0, 1'b0};

      #2;
      cmp("reset strobe", write_strobe, 0);
      cmp("reset address", address, 0);
      cmp("reset data", data, 0);
      cmp("reset busy", busy, 0);
      cmp("reset step", step_idx, 0);
      cmp("reset done", done, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      prog(3'd0, 4'd1, 3'd0, 5'd5);
      prog(3'd1, 4'd0, 3'd2, 5'd9);

      // basic two-step playback, every output every cycle
      for (int i = 0; i < 10; i++) begin
         start = tbl[i].start; length = tbl[i].len; loop = 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
         cmp($sformatf("tbl%0d strobe", i), write_strobe, tbl[i].ws);
         cmp($sformatf("tbl%0d address", i), address, tbl[i].a);
         cmp($sformatf("tbl%0d data", i), data, tbl[i].d);
         cmp($sformatf("tbl%0d busy", i), busy, tbl[i].busy);
         cmp($sformatf("tbl%0d step", i), step_idx, tbl[i].step);
         cmp($sformatf("tbl%0d done", i), done, tbl[i].done);
      end

      // looping playback, then stop while in ISSUE
      loop = 1'b1; length = 4'd2;
      for (int c = 1; c <= 16; c++) begin
         bit e0, e1;
         start = (c == 1);
         e0 = (c == 3) || (c == 11);
         e1 = (c == 9);
         cyc_chk("loop", c, e0 || e1, e0 ? 3'd0 : 3'd2, e0 ? 5'd5 : 5'd9, 1'b1, 1'b0);
      end
      start = 1'b0; stop = 1'b1;
      cyc_chk("loopstop", 17, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
      cmp("loopstop step", step_idx, 0);
      stop = 1'b0; loop = 1'b0;
      for (int c = 18; c <= 22; c++) cyc_chk("loopstop", c, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);

      // host holds the bus for 3 cycles while sequencer sits in ISSUE
      for (int c = 1; c <= 13; c++) begin
         bit eh, e0, e1;
         start = (c == 1);
         host_strobe = (c >= 3 && c <= 5); host_address = 3'd4; host_data = 5'd3;
         eh = (c >= 3 && c <= 5); e0 = (c == 6); e1 = (c == 12);
         cyc_chk("host", c, eh || e0 || e1, eh ? 3'd4 : (e0 ? 3'd0 : 3'd2),
                 eh ? 5'd3 : (e0 ? 5'd5 : 5'd9), c < 12, c == 12);
      end
      host_strobe = 1'b0;

      // rewrite entry 1 while waiting on entry 0
      for (int c = 1; c <= 10; c++) begin
         start = (c == 1);
         prog_we = (c == 4); prog_addr = 3'd1; prog_data = {4'd0, 3'd6, 5'd17};
         cyc_chk("rewrite", c, c == 3 || c == 9, c == 3 ? 3'd0 : 3'd6,
                 c == 3 ? 5'd5 : 5'd17, c < 9, c == 9);
      end
      prog_we = 1'b0;

      // start and stop together while busy
      for (int c = 1; c <= 9; c++) begin
         start = (c == 1) || (c == 5);
         stop  = (c == 5);
         cyc_chk("startstop", c, c == 3, 3'd0, 5'd5, c < 5, 1'b0);
         if (c == 5) cmp("startstop step", step_idx, 0);
      end
      start = 1'b0; stop = 1'b0;

      // zero length is ignored
      length = 4'd0;
      for (int c = 1; c <= 4; c++) begin
         start = (c == 1);
         cyc_chk("len0", c, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
      end
      start = 1'b0;

      // length 12 clamps to 8 entries
      for (int i = 0; i < 8; i++) prog(3'(i), 4'd0, 3'(i), 5'(i + 10));
      length = 4'd12;
      for (int c = 1; c <= 18; c++) begin
         bit ew;
         int k;
         start = (c == 1);
         ew = (c >= 3) && (c <= 17) && (((c - 3) % 2) == 0);
         k = (c - 3) / 2;
         cyc_chk("len12", c, ew, 3'(k), 5'(k + 10), c < 17, c == 17);
      end
      start = 1'b0;

      // asynchronous reset in the middle of WAIT
      prog(3'd0, 4'd1, 3'd0, 5'd5);
      prog(3'd1, 4'd0, 3'd2, 5'd9);
      length = 4'd2;
      for (int c = 1; c <= 4; c++) begin
         start = (c == 1);
         cyc_chk("prerst", c, c == 3, 3'd0, 5'd5, 1'b1, 1'b0);
      end
      start = 1'b0;
      #3 rst = 1'b1;
      #1;
      cmp("midrst strobe", write_strobe, 0);
      cmp("midrst address", address, 0);
      cmp("midrst data", data, 0);
      cmp("midrst busy", busy, 0);
      cmp("midrst step", step_idx, 0);
      cmp("midrst done", done, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      // program memory was cleared, so entry 0 replays as a0 d0 dly0
      length = 4'd1;
      for (int c = 1; c <= 4; c++) begin
         start = (c == 1);
         cyc_chk("postrst", c, c == 3, 3'd0, 5'd0, c < 3, c == 3);
         if (c == 3) cmp("postrst data", data, 0);
      end
      start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Autonomous register-write sequencer placed in front of signal_generator's write_strobe/address/data bus.
- Plays a programmable list of up to 8 (address, data, delay) steps, with tick-based gaps between writes. Drives note changes, volume sweeps and enable toggles without host involvement.
- Arbitrates the single write bus between direct host writes and the sequencer. The host always wins.

Parameters:
- TICK_DIV, 1000, clocks per delay tick (>=1)
- DELAY_W, 4, width of per-step delay field in ticks

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- prog_we  in  1  program-memory write enable
- prog_addr  in  3  program entry index
- prog_data  in  8+DELAY_W  entry {delay[DELAY_W-1:0], address[2:0], data[4:0]}
- start  in  1  pulse: begin playback at entry 0
- stop  in  1  pulse: abort playback
- loop  in  1  level: wrap to entry 0 after last step
- length  in  4  number of active entries (0..8, values >8 clamp to 8)
- host_strobe  in  1  direct host write request
- host_address  in  3  direct write address
- host_data  in  5  direct write data
- write_strobe  out  1  to signal_generator
- address  out  3  to signal_generator
- data  out  5  to signal_generator
- busy  out  1  sequencer not IDLE
- step_idx  out  3  entry currently fetched/issued/waiting
- done  out  1  one-cycle pulse at end of non-looping playback

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE; step_idx 0; prescaler and delay counter 0.
  - All outputs 0.
  - Program memory (8 entries, flops) cleared to 0.
- Outputs: write_strobe/address/data are registered.
  - A bus write appears the cycle after it is decided.
  - write_strobe is high for exactly one cycle per write.
  - address/data hold their last value when the strobe is low.
- Program memory:
  - prog_we writes the entry at prog_addr on the clock edge. Legal in any state.
  - An entry rewritten during playback takes effect the next time that entry is fetched.
- States:
  - IDLE: start with length!=0 -> FETCH, step_idx=0. start with length==0 is ignored (no done).
  - FETCH (1 cycle): latch entry[step_idx] -> ISSUE.
  - ISSUE:
    - If host_strobe is high: the host write is issued this cycle and the sequencer stays in ISSUE (1-cycle stall per collision).
    - Otherwise: issue the latched address/data and load the delay counter with delay. delay==0 -> ADVANCE directly; else -> WAIT, prescaler=0.
  - WAIT:
    - Prescaler counts 0..TICK_DIV-1. The delay counter decrements on each wrap.
    - When the delay counter reaches 0 at a wrap -> ADVANCE. WAIT lasts exactly delay*TICK_DIV cycles.
  - ADVANCE (combinational within the leaving cycle):
    - If step_idx==length-1: loop=1 -> step_idx=0, FETCH; loop=0 -> done pulse next cycle, IDLE.
    - Otherwise step_idx+1 -> FETCH.
- Timing: with no host contention, sequencer strobe-to-strobe spacing = delay*TICK_DIV + 2 cycles, where delay is that of the earlier entry.
- Host path:
  - host_strobe is accepted every cycle in every state and forwarded with 1-cycle latency.
  - Never dropped, never delayed more than 1 cycle.
- stop:
  - Any state -> IDLE next edge. No sequencer strobe is issued in the stop cycle.
  - step_idx resets to 0; no done pulse.
  - A host write in the same cycle still passes.
- start while busy: restart at entry 0 via FETCH. Any pending delay is discarded.
- Simultaneous start and stop: stop wins.
- Changes to length or loop are sampled at each ADVANCE. If length drops below step_idx+1, the next ADVANCE ends playback (or wraps if loop=1).
- busy = (state != IDLE). done is never asserted together with busy rising.

Test Plan:
- Reset mid-WAIT (TICK_DIV=4) -> all outputs 0 immediately (async), busy 0; after release, start replays from entry 0.
- Program entries {0:a0 d5 dly1, 1:a2 d9 dly0}, length=2, loop=0, TICK_DIV=4, start -> strobe (0,5); strobe (2,9) 6 cycles later; done 1 cycle after leaving the second ISSUE; busy low after.
- Same program with loop=1 -> strobe pattern repeats: entry1 to entry0 spacing 2 cycles, entry0 to entry1 spacing 6; no done; stop -> no further strobes, busy 0 next cycle.
- host_strobe (a=4, d=3) held 3 cycles while the sequencer sits in ISSUE -> three host strobes (4,3), then the sequencer strobe on the 4th cycle; spacing grows by 3.
- length=0 start -> no strobe, busy stays 0, no done. length=12 -> plays 8 entries then done.
- start and stop asserted in the same cycle while busy -> IDLE; rewrite entry 1 via prog_we during WAIT on entry 0 -> the new entry 1 value is issued.
